// File: rtl/cpu_bus.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_bus: CPU memory decoder (work RAM / PRG handshake / open bus).        |
// | Option: CPU_BUS_TIMEOUT_EN adds a PRG ack watchdog and bus_error_o. Rev 1 |
// +--------------------------------------------------------------------------+
module cpu_bus #(
  parameter int RAM_ADDR_WIDTH = 11,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] cpu_address_i,
  input  logic        cpu_address_valid_i,
  input  logic        cpu_write_i,
  input  logic [7:0]  cpu_data_i,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_data_valid_o,
  output logic        prg_req_o,
  output logic [14:0] prg_address_o,
  input  logic        prg_ack_i,
  input  logic [7:0]  prg_data_i,
  output logic        bus_error_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256 || RAM_ADDR_WIDTH < 1 || RAM_ADDR_WIDTH > 13)
  begin : g_param_check
    $error("cpu_bus: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_RAM, S_PRG, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        served_q, served_d;
  logic        abort_q, abort_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  obus_q, obus_d;
  logic        req_q, req_d;
  logic [14:0] prg_addr_q, prg_addr_d;
  logic [7:0]  ram_q;
  logic [7:0]  ram_mem [2**RAM_ADDR_WIDTH];

  logic                      w_match;
  logic                      w_launch;
  logic                      w_in_ram;
  logic                      w_in_prg;
  logic                      w_timeout;
  logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;

  assign w_match   = ({cpu_address_i, cpu_write_i, cpu_data_i} == {addr_q, write_q, wdata_q});
  assign w_launch  = (state_q == S_IDLE) && cpu_address_valid_i && (!w_match || !served_q);
  assign w_in_ram  = (cpu_address_i[15:13] == 3'b000);
  assign w_in_prg  = cpu_address_i[15];
  assign w_ram_idx = cpu_address_i[RAM_ADDR_WIDTH-1:0];

  assign cpu_data_o       = rdata_q;
  assign cpu_data_valid_o = served_q && cpu_address_valid_i && w_match;
  assign prg_req_o        = req_q;
  assign prg_address_o    = prg_addr_q;

`ifdef CPU_BUS_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       bus_error_q;

  assign w_timeout   = (state_q == S_PRG) && !prg_ack_i && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign bus_error_o = bus_error_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      wait_cnt_q <= (state_q == S_PRG) ? wait_cnt_q + 8'd1 : 8'd0;
      if (w_timeout) bus_error_q <= 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign bus_error_o = 1'b0;
`endif

  // Work RAM is never reset; writes land on the launch edge.
  always_ff @(posedge clock_i) begin
    if (w_launch) begin
      if (cpu_write_i && w_in_ram) ram_mem[w_ram_idx] <= cpu_data_i;
      ram_q <= ram_mem[w_ram_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    served_d   = served_q;
    abort_d    = abort_q;
    rdata_d    = rdata_q;
    obus_d     = obus_q;
    req_d      = req_q;
    prg_addr_d = prg_addr_q;
    case (state_q)
      S_IDLE: begin
        if (w_launch) begin
          addr_d   = cpu_address_i;
          write_d  = cpu_write_i;
          wdata_d  = cpu_data_i;
          served_d = 1'b0;
          abort_d  = 1'b0;
          if (cpu_write_i) begin
            obus_d  = cpu_data_i;
            state_d = S_DONE;
          end else if (w_in_ram) begin
            state_d = S_RAM;
          end else if (w_in_prg) begin
            req_d      = 1'b1;
            prg_addr_d = cpu_address_i[14:0];
            state_d    = S_PRG;
          end else begin
            rdata_d = obus_q;
            state_d = S_DONE;
          end
        end
      end
      S_RAM: begin
        abort_d = abort_q || !w_match;
        if (!abort_d) begin
          rdata_d = ram_q;
          obus_d  = ram_q;
        end
        state_d = S_DONE;
      end
      S_PRG: begin
        // A changed request still lets the handshake finish; only the result is dropped.
        abort_d = abort_q || !w_match;
        if (prg_ack_i) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!abort_d) begin
            rdata_d = prg_data_i;
            obus_d  = prg_data_i;
          end
        end else if (w_timeout) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!abort_d) rdata_d = obus_q;
        end
      end
      S_DONE: begin
        served_d = !abort_q && w_match;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      served_q   <= 1'b0;
      abort_q    <= 1'b0;
      rdata_q    <= '0;
      obus_q     <= '0;
      req_q      <= 1'b0;
      prg_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      served_q   <= served_d;
      abort_q    <= abort_d;
      rdata_q    <= rdata_d;
      obus_q     <= obus_d;
      req_q      <= req_d;
      prg_addr_q <= prg_addr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_bus: directed and random transactions against a byte-level model.  |
// | Rev 1                                                                     |
// +--------------------------------------------------------------------------+
module tb_cpu_bus;

  localparam int TO_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic        av = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  wd = '0;
  logic [7:0]  rd;
  logic        valid;
  logic        req;
  logic [14:0] paddr;
  logic        ack = 1'b0;
  logic [7:0]  pdat = '0;
  logic        berr;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  ram_m [2048];
  logic [7:0]  obus_m = 8'h00;
  logic [24:0] prev_t = '1;

  cpu_bus #(.RAM_ADDR_WIDTH(11), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clock_i            (clk),
    .reset_i            (rst),
    .cpu_address_i      (addr),
    .cpu_address_valid_i(av),
    .cpu_write_i        (wr),
    .cpu_data_i         (wd),
    .cpu_data_o         (rd),
    .cpu_data_valid_o   (valid),
    .prg_req_o          (req),
    .prg_address_o      (paddr),
    .prg_ack_i          (ack),
    .prg_data_i         (pdat),
    .bus_error_o        (berr)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request held until served; latency counted in edges from the launch edge E0.
  task automatic run_txn(input logic [15:0] a, input logic w, input logic [7:0] d_in,
                         input int dly, input logic [7:0] pd);
    int         first;
    int         exp_lat;
    logic [7:0] exp_data;
    logic [7:0] d;
    logic       is_prg_rd;
    d = d_in;
    if ({a, w, d} == prev_t) d = d ^ 8'h01;
    exp_data  = 8'h00;
    is_prg_rd = !w && a[15];
    if (w) begin
      exp_lat = 1;
      if (a < 16'h2000) ram_m[a[10:0]] = d;
      obus_m = d;
    end else if (a < 16'h2000) begin
      exp_lat  = 2;
      exp_data = ram_m[a[10:0]];
      obus_m   = exp_data;
    end else if (a[15]) begin
      exp_lat  = dly + 1;
      exp_data = pd;
      obus_m   = pd;
    end else begin
      exp_lat  = 1;
      exp_data = obus_m;
    end
    @(negedge clk);
    addr = a; wr = w; wd = d; av = 1'b1;
    prev_t = {a, w, d};
    #1;
    chk("stale_drop", {31'd0, valid}, 32'd0);
    first = -1;
    for (int k = 0; k < 40 && first < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (is_prg_rd) begin
        if (k == 0) chk("prg_addr", {17'd0, paddr}, {17'd0, a[14:0]});
        if (k == dly - 1) begin
          chk("req_held", {31'd0, req}, 32'd1);
          ack = 1'b1;
          pdat = pd;
        end
        if (k == dly) begin
          ack = 1'b0;
          chk("req_drop", {31'd0, req}, 32'd0);
        end
      end else if (k == 0) begin
        chk("no_req", {31'd0, req}, 32'd0);
      end
      if (valid) first = k;
    end
    ack = 1'b0;
    chk("latency", first, exp_lat);
    if (!w) chk("rdata", {24'd0, rd}, {24'd0, exp_data});
  endtask

  initial begin
    int first;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", {24'd0, rd}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_paddr", {17'd0, paddr}, 32'd0);
    chk("rst_berr", {31'd0, berr}, 32'd0);
    rst = 1'b0;

    // Mirror, PRG handshake, open bus, discarded PRG write.
    run_txn(16'h0123, 1'b1, 8'h5A, 0, 8'h00);
    run_txn(16'h0923, 1'b0, 8'h00, 0, 8'h00);
    run_txn(16'hFFFC, 1'b0, 8'h00, 3, 8'h34);
    run_txn(16'h4020, 1'b0, 8'h00, 0, 8'h00);
    run_txn(16'h8000, 1'b1, 8'hC3, 0, 8'h00);

    for (int i = 0; i < 32; i++)
      run_txn(16'(((i % 4) << 11) | i), 1'b1, 8'($urandom), 0, 8'h00);

    // Request changes from PRG to RAM while the cartridge has not answered.
    @(negedge clk);
    addr = 16'h8000; wr = 1'b0; wd = 8'h00; av = 1'b1;
    first = -1;
    for (int k = 0; k < 40 && first < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) addr = 16'h0010;
      if (k == 2) begin
        chk("abort_req_held", {31'd0, req}, 32'd1);
        ack = 1'b1;
        pdat = 8'hEE;
      end
      if (k == 3) ack = 1'b0;
      if (valid) first = k;
    end
    ack = 1'b0;
    chk("abort_latency", first, 7);
    chk("abort_rdata", {24'd0, rd}, {24'd0, ram_m[16]});
    obus_m = ram_m[16];
    prev_t = {16'h0010, 1'b0, 8'h00};

    for (int i = 0; i < 200; i++) begin
      logic [15:0] a;
      logic        w;
      int          kind;
      kind = int'($urandom_range(0, 2));
      w    = 1'($urandom_range(0, 1));
      if (kind == 0)      a = 16'(($urandom_range(0, 3) << 11) | $urandom_range(0, 31));
      else if (kind == 1) a = 16'(16'h2000 + $urandom_range(0, 16'h5FFF));
      else                a = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      run_txn(a, w, 8'($urandom), int'($urandom_range(1, 3)), 8'($urandom));
    end

    // Reset with a PRG request outstanding; a late ack must be ignored.
    @(negedge clk);
    addr = 16'h9000; wr = 1'b0; wd = 8'h00; av = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_req", {31'd0, req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_req", {31'd0, req}, 32'd0);
    chk("async_rst_valid", {31'd0, valid}, 32'd0);
    av = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b1;
    pdat = 8'h77;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    chk("late_ack_req", {31'd0, req}, 32'd0);
    chk("late_ack_rdata", {24'd0, rd}, 32'd0);
    obus_m = 8'h00;
    prev_t = '1;
    run_txn(16'h5000, 1'b0, 8'h00, 0, 8'h00);
    run_txn(16'h0823, 1'b0, 8'h00, 0, 8'h00);

`ifdef CPU_BUS_TIMEOUT_EN
    @(negedge clk);
    addr = 16'hA000; wr = 1'b0; wd = 8'h3C; av = 1'b1;
    first = -1;
    for (int k = 0; k < 40 && first < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == TO_CYCLES - 1) chk("to_req_held", {31'd0, req}, 32'd1);
      if (k == TO_CYCLES) chk("to_req_drop", {31'd0, req}, 32'd0);
      if (valid) first = k;
    end
    chk("to_latency", first, TO_CYCLES + 1);
    chk("to_rdata", {24'd0, rd}, {24'd0, obus_m});
    chk("to_berr", {31'd0, berr}, 32'd1);
    prev_t = {16'hA000, 1'b0, 8'h3C};
    run_txn(16'h0005, 1'b1, 8'h11, 0, 8'h00);
    chk("berr_sticky", {31'd0, berr}, 32'd1);
`else
    chk("berr_tied", {31'd0, berr}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
